// File: rtl/project_pwm_pkg.sv
// Shared types and constants for the SPI register bridge: FSM encoding,
// command-byte layout and the write-lock key/address.
package project_pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_PREFETCH,
        ST_DATA
    } bridge_state_t;

    localparam int CMD_W_BIT   = 7;
    localparam int CMD_INC_BIT = 6;

    localparam logic [7:0] LOCK_KEY  = 8'hA5;
    localparam logic [5:0] LOCK_ADDR = 6'd63;

    function automatic logic is_lock_addr(input logic [5:0] addr);
        return addr == LOCK_ADDR;
    endfunction

    function automatic logic is_unlock_key(input logic [7:0] data);
        return data == LOCK_KEY;
    endfunction

endpackage

// File: rtl/project_sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous pin, with single-cycle
// rise/fall pulses derived from the last two synchronized samples.
module project_sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/project_spi_register_bridge.sv
// SPI mode-0 target driving the register-file bus (write strobe, address,
// data) and returning read data on MISO. Optional write lock: PROJECT_SPI_WRITE_LOCK_EN.
//
// state    | meaning
// IDLE     | no frame, waiting for CS_n low
// CMD      | shifting in the command byte
// PREFETCH | loading i_rdata at the current address into the MISO shifter
// DATA     | shifting data bytes in (MOSI) and out (MISO)
module project_spi_register_bridge
    import project_pwm_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 6,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_sck,
    input  logic                     i_cs_n,
    input  logic                     i_mosi,
    output logic                     o_miso,
    output logic                     o_write_en,
    output logic [ADDRESS_WIDTH-1:0] o_address,
    output logic [7:0]               o_wdata,
    input  logic [7:0]               i_rdata,
    output logic                     o_busy,
    output logic                     o_frame_error
);

    logic sck_rise, sck_fall, sck_level_unused;
    logic cs_level, cs_rise_unused, cs_fall_unused;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    project_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(i_clk), .rst(i_reset), .din(i_sck),
        .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );

    // CS_n idles high, so its synchronizer must come out of reset deasserted.
    project_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(i_clk), .rst(i_reset), .din(i_cs_n),
        .level(cs_level), .rise(cs_rise_unused), .fall(cs_fall_unused)
    );

    project_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(i_clk), .rst(i_reset), .din(i_mosi),
        .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    bridge_state_t state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_in;
    logic [7:0]    shift_out;
    logic          w_flag;
    logic          inc_flag;
    logic          byte_done;
    logic [7:0]    rx_byte;
    logic          shifting;
`ifdef PROJECT_SPI_WRITE_LOCK_EN
    logic          unlocked;
`endif

    assign rx_byte  = {shift_in[6:0], mosi_level};
    assign shifting = (state == ST_CMD) || (state == ST_DATA);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            shift_in      <= '0;
            shift_out     <= '0;
            w_flag        <= 1'b0;
            inc_flag      <= 1'b0;
            byte_done     <= 1'b0;
            o_miso        <= 1'b0;
            o_write_en    <= 1'b0;
            o_address     <= '0;
            o_wdata       <= '0;
            o_busy        <= 1'b0;
            o_frame_error <= 1'b0;
`ifdef PROJECT_SPI_WRITE_LOCK_EN
            unlocked      <= 1'b0;
`endif
        end else begin
            o_write_en    <= 1'b0;
            o_frame_error <= 1'b0;
            byte_done     <= 1'b0;

            // Auto-increment lands the cycle after the strobe, so the strobe sees a stable address.
            if (byte_done && inc_flag) begin
                o_address <= o_address + 1'b1;
            end

            if (state != ST_IDLE && cs_level) begin
                state   <= ST_IDLE;
                o_busy  <= 1'b0;
                bit_cnt <= '0;
                if (bit_cnt != 3'd0) begin
                    o_frame_error <= 1'b1;
                end
            end else begin
                if (shifting && sck_fall) begin
                    o_miso    <= shift_out[7];
                    shift_out <= {shift_out[6:0], 1'b0};
                end
                if (shifting && sck_rise) begin
                    bit_cnt  <= bit_cnt + 1'b1;
                    shift_in <= rx_byte;
                end

                case (state)
                    ST_IDLE: begin
                        if (!cs_level) begin
                            state     <= ST_CMD;
                            o_busy    <= 1'b1;
                            bit_cnt   <= '0;
                            shift_in  <= '0;
                            shift_out <= '0;
                            o_miso    <= 1'b0;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise && bit_cnt == 3'd7) begin
                            o_address <= ADDRESS_WIDTH'(rx_byte[5:0]);
                            w_flag    <= rx_byte[CMD_W_BIT];
                            inc_flag  <= rx_byte[CMD_INC_BIT];
                            state     <= rx_byte[CMD_W_BIT] ? ST_DATA : ST_PREFETCH;
                        end
                    end
                    ST_PREFETCH: begin
                        // Wait out a pending increment so i_rdata reflects the new address.
                        if (!byte_done) begin
                            shift_out <= i_rdata;
                            state     <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (sck_rise && bit_cnt == 3'd7) begin
                            byte_done <= 1'b1;
                            if (w_flag) begin
                                o_wdata <= rx_byte;
`ifdef PROJECT_SPI_WRITE_LOCK_EN
                                if (is_lock_addr(o_address)) begin
                                    unlocked <= is_unlock_key(rx_byte);
                                end else begin
                                    o_write_en <= unlocked;
                                end
`else
                                o_write_en <= 1'b1;
`endif
                            end else begin
                                state <= ST_PREFETCH;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_project_spi_register_bridge.sv
// Directed bench for project_spi_register_bridge: table of SPI frames with
// expected strobes / MISO bytes, plus truncation, empty-frame and reset sequences.
module tb_project_spi_register_bridge;

    localparam int HALF = 6;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       sck     = 1'b0;
    logic       cs_n    = 1'b1;
    logic       mosi    = 1'b0;
    logic       rd_mode = 1'b0;
    logic       miso, write_en, busy, frame_error;
    logic [5:0] address;
    logic [7:0] wdata, rdata;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    logic [5:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];

    typedef struct packed {
        logic [7:0]      cmd;
        logic [1:0]      n;
        logic            mode;
        logic [2:0][7:0] tx;
        logic [1:0]      exp_wr;
        logic [2:0][5:0] exp_addr;
        logic [2:0][7:0] exp_data;
        logic [2:0][7:0] exp_rx;
        logic [5:0]      exp_final;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    project_spi_register_bridge dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_sck         (sck),
        .i_cs_n        (cs_n),
        .i_mosi        (mosi),
        .o_miso        (miso),
        .o_write_en    (write_en),
        .o_address     (address),
        .o_wdata       (wdata),
        .i_rdata       (rdata),
        .o_busy        (busy),
        .o_frame_error (frame_error)
    );

    assign rdata = rd_mode ? ({2'b00, address} ^ 8'h5A) : 8'hC3;

    always @(negedge clk) begin
        if (write_en) begin
            wr_addr_q.push_back(address);
            wr_data_q.push_back(wdata);
        end
        if (frame_error) err_cnt++;
    end

    function automatic vec_t mk(input int cmd, input int n, input int mode,
                                input int t0, input int t1, input int t2, input int nw,
                                input int a0, input int d0, input int a1, input int d1,
                                input int a2, input int d2,
                                input int r0, input int r1, input int r2, input int fin);
        vec_t v;
        v.cmd = cmd[7:0];   v.n = n[1:0];     v.mode = mode[0];
        v.tx[0] = t0[7:0];  v.tx[1] = t1[7:0]; v.tx[2] = t2[7:0];
        v.exp_wr = nw[1:0];
        v.exp_addr[0] = a0[5:0]; v.exp_data[0] = d0[7:0];
        v.exp_addr[1] = a1[5:0]; v.exp_data[1] = d1[7:0];
        v.exp_addr[2] = a2[5:0]; v.exp_data[2] = d2[7:0];
        v.exp_rx[0] = r0[7:0]; v.exp_rx[1] = r1[7:0]; v.exp_rx[2] = r2[7:0];
        v.exp_final = fin[5:0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        err_cnt = 0;
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = miso;
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int n, input logic [2:0][7:0] tx,
                             output logic [7:0] cmd_rx, output logic [2:0][7:0] rx,
                             output logic busy_mid);
        logic [7:0] b;
        rx = '0;
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        busy_mid = busy;
        spi_xfer(cmd, 8, cmd_rx);
        for (int k = 0; k < n; k++) begin
            spi_xfer(tx[k], 8, b);
            rx[k] = b;
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic write_frame(input logic [7:0] cmd, input logic [7:0] data);
        logic [7:0]      c_rx;
        logic [2:0][7:0] rx;
        logic [2:0][7:0] tx;
        logic            bm;
        tx = '0;
        tx[0] = data;
        run_frame(cmd, 1, tx, c_rx, rx, bm);
    endtask

    task automatic check_single_write(input string name, input int exp_n,
                                      input logic [5:0] a, input logic [7:0] d);
        check({name, "_wr_count"}, 32'(wr_addr_q.size()), 32'(exp_n));
        if (exp_n == 1 && wr_addr_q.size() == 1) begin
            check({name, "_wr_addr"}, 32'(wr_addr_q[0]), 32'(a));
            check({name, "_wr_data"}, 32'(wr_data_q[0]), 32'(d));
        end
    endtask

    initial begin
        logic [7:0]      c_rx, b;
        logic [2:0][7:0] rx;
        logic            bm;
        int              nw5;

`ifdef PROJECT_SPI_WRITE_LOCK_EN
        nw5 = 1;
`else
        nw5 = 3;
`endif
        vecs[0] = mk('h82, 1, 0, 'h80, 0, 0, 1, 'h02, 'h80, 0, 0, 0, 0, 0, 0, 0, 'h02);
        vecs[1] = mk('h05, 1, 0, 'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hC3, 0, 0, 'h05);
        vecs[2] = mk('h50, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h4A, 'h4B, 0, 'h12);
        vecs[3] = mk('h81, 2, 0, 'h5A, 'h6B, 0, 2, 'h01, 'h5A, 'h01, 'h6B, 0, 0, 0, 0, 0, 'h01);
        vecs[4] = mk('h07, 2, 1, 'hAA, 'h55, 0, 0, 0, 0, 0, 0, 0, 0, 'h5D, 'h5D, 0, 'h07);
        vecs[5] = mk('hFE, 3, 0, 'h11, 'h22, 'h33, nw5, 'h3E, 'h11, 'h3F, 'h22, 'h00, 'h33,
                     0, 0, 0, 'h01);

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({miso, write_en, busy, frame_error, address, wdata}), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_after_reset", 32'({busy, write_en, frame_error}), 32'h0);

`ifdef PROJECT_SPI_WRITE_LOCK_EN
        clear_mon();
        write_frame(8'h82, 8'h80);
        check_single_write("locked_write", 0, 6'h00, 8'h00);
        clear_mon();
        write_frame(8'hBF, 8'hA5);
        check_single_write("unlock_consumed", 0, 6'h00, 8'h00);
`endif

        for (int i = 0; i < 6; i++) begin
            clear_mon();
            rd_mode = vecs[i].mode;
            run_frame(vecs[i].cmd, int'(vecs[i].n), vecs[i].tx, c_rx, rx, bm);
            check($sformatf("v%0d_busy_mid", i), 32'(bm), 32'h1);
            check($sformatf("v%0d_busy_end", i), 32'(busy), 32'h0);
            check($sformatf("v%0d_cmd_miso", i), 32'(c_rx), 32'h0);
            check($sformatf("v%0d_wr_count", i), 32'(wr_addr_q.size()), 32'(vecs[i].exp_wr));
            for (int k = 0; k < int'(vecs[i].exp_wr) && k < wr_addr_q.size(); k++) begin
                check($sformatf("v%0d_wr%0d_addr", i, k), 32'(wr_addr_q[k]), 32'(vecs[i].exp_addr[k]));
                check($sformatf("v%0d_wr%0d_data", i, k), 32'(wr_data_q[k]), 32'(vecs[i].exp_data[k]));
            end
            for (int k = 0; k < int'(vecs[i].n); k++) begin
                check($sformatf("v%0d_rx%0d", i, k), 32'(rx[k]), 32'(vecs[i].exp_rx[k]));
            end
            check($sformatf("v%0d_final_addr", i), 32'(address), 32'(vecs[i].exp_final));
            check($sformatf("v%0d_errors", i), 32'(err_cnt), 32'h0);
        end
        rd_mode = 1'b0;

`ifdef PROJECT_SPI_WRITE_LOCK_EN
        clear_mon();
        write_frame(8'hBF, 8'hA5);
        check_single_write("relock_unlock", 0, 6'h00, 8'h00);
`endif

        // Empty frame: CS_n low with no clocks is not an error.
        clear_mon();
        cs_n = 1'b0;
        repeat (10) @(negedge clk);
        check("empty_busy", 32'(busy), 32'h1);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        check("empty_errors", 32'(err_cnt), 32'h0);
        check("empty_busy_end", 32'(busy), 32'h0);

        // Truncated write: 5 data bits then CS_n high.
        clear_mon();
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_xfer(8'h82, 8, b);
        spi_xfer(8'h55, 5, b);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (20) @(negedge clk);
        check("trunc_wr_count", 32'(wr_addr_q.size()), 32'h0);
        check("trunc_error_cycles", 32'(err_cnt), 32'h1);

        clear_mon();
        write_frame(8'h83, 8'h9C);
        check_single_write("after_trunc", 1, 6'h03, 8'h9C);
        check("after_trunc_errors", 32'(err_cnt), 32'h0);

        // Reset in the middle of a write frame.
        clear_mon();
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_xfer(8'h82, 8, b);
        spi_xfer(8'h44, 4, b);
        rst = 1'b1;
        #1;
        check("midreset_outputs", 32'({miso, write_en, busy, frame_error, address, wdata}), 32'h0);
        cs_n = 1'b1;
        sck  = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("midreset_wr_count", 32'(wr_addr_q.size()), 32'h0);
        check("midreset_errors", 32'(err_cnt), 32'h0);

        clear_mon();
        write_frame(8'h84, 8'h77);
`ifdef PROJECT_SPI_WRITE_LOCK_EN
        check_single_write("post_reset_locked", 0, 6'h00, 8'h00);
`else
        check_single_write("post_reset", 1, 6'h04, 8'h77);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
